// File: rtl/xmul_mac.sv
`default_nettype none
// ============================================================================
//  Module   : xmul_mac
//  Purpose  : Pipelined multiply / multiply-accumulate unit. It picks two
//             operands from the shared flow bus and streams their products
//             through a configurable pipeline. MAC mode accumulates a
//             programmed number of samples, then scales and saturates.
//  Revision : 1.0  initial release
// ============================================================================
module xmul_mac #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 16,
    parameter int SEL_W  = 4,
    parameter int PIPE   = 2,
    parameter int GUARD  = 8,
    parameter int LEN_W  = 16,
    localparam int ACC_W   = 2 * DATA_W + GUARD,
    localparam int SHIFT_W = $clog2(ACC_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC*DATA_W-1:0] flow_in,
    input  logic [SEL_W-1:0]        cfg_sela,
    input  logic [SEL_W-1:0]        cfg_selb,
    input  logic [1:0]              cfg_fns,
    input  logic                    cfg_signed,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic                    run,
    output logic                    busy,
    output logic                    done,
    output logic                    sat,
    output logic [DATA_W-1:0]       flow_out
);

    localparam int PROD_W = 2 * DATA_W;

    localparam logic [1:0] FN_LO   = 2'd0;
    localparam logic [1:0] FN_HI   = 2'd1;
    localparam logic [1:0] FN_DIV2 = 2'd2;
    localparam logic [1:0] FN_MAC  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Control state and latched configuration
    state_t               state_q;
    logic [SEL_W-1:0]     sela_q;
    logic [SEL_W-1:0]     selb_q;
    logic [1:0]           fns_q;
    logic                 sgn_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [LEN_W-1:0]     cnt_q;
    logic                 first_q;

    // Datapath pipeline: operand stage followed by PIPE product stages
    logic [DATA_W-1:0]    opa_q;
    logic [DATA_W-1:0]    opb_q;
    logic                 opv_q;
    logic                 opl_q;
    logic [PROD_W-1:0]    prod_q [PIPE];
    logic [PIPE-1:0]      pv_q;
    logic [PIPE-1:0]      pl_q;
    logic [ACC_W-1:0]     acc_q;

    // Registered outputs
    logic [DATA_W-1:0]    flow_out_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 sat_q;

    // Combinational helpers
    logic [DATA_W-1:0]    opa_d;
    logic [DATA_W-1:0]    opb_d;
    logic [PROD_W-1:0]    a_ext_d;
    logic [PROD_W-1:0]    b_ext_d;
    logic [PROD_W-1:0]    prod_d;
    logic [PROD_W-1:0]    p_tail;
    logic [DATA_W-1:0]    res_d;
    logic [ACC_W-1:0]     pext_d;
    logic [ACC_W-1:0]     acc_d;
    logic [ACC_W-1:0]     shr_d;
    logic [DATA_W-1:0]    clamp_d;
    logic                 sat_d;

    // Operand selection from the flow bus; selects beyond N_SRC read zero
    always_comb begin
        opa_d = '0;
        opb_d = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (int'(sela_q) == k) opa_d = flow_in[k*DATA_W +: DATA_W];
            if (int'(selb_q) == k) opb_d = flow_in[k*DATA_W +: DATA_W];
        end
    end

    // Product: extending both operands to full product width makes the low
    // PROD_W bits of a plain multiply correct for both signednesses
    always_comb begin
        a_ext_d = sgn_q ? {{DATA_W{opa_q[DATA_W-1]}}, opa_q} : {{DATA_W{1'b0}}, opa_q};
        b_ext_d = sgn_q ? {{DATA_W{opb_q[DATA_W-1]}}, opb_q} : {{DATA_W{1'b0}}, opb_q};
        prod_d  = a_ext_d * b_ext_d;
    end

    // Result selection, accumulation, scaling and clamping at the pipe tail
    always_comb begin
        p_tail = prod_q[PIPE-1];
        case (fns_q)
            FN_LO:   res_d = p_tail[DATA_W-1:0];
            FN_HI:   res_d = p_tail[PROD_W-2 -: DATA_W];
            default: res_d = p_tail[PROD_W-1 -: DATA_W];
        endcase

        pext_d = sgn_q ? {{GUARD{p_tail[PROD_W-1]}}, p_tail} : {{GUARD{1'b0}}, p_tail};
        acc_d  = first_q ? pext_d : (acc_q + pext_d);

        if (sgn_q) shr_d = $signed(acc_d) >>> shift_q;
        else       shr_d = acc_d >> shift_q;

        clamp_d = shr_d[DATA_W-1:0];
        sat_d   = 1'b0;
        if (sgn_q) begin
            // Fits when every bit from the DATA_W sign bit upwards agrees
            if (!((&shr_d[ACC_W-1:DATA_W-1]) || (~|shr_d[ACC_W-1:DATA_W-1]))) begin
                sat_d   = 1'b1;
                clamp_d = shr_d[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            if (|shr_d[ACC_W-1:DATA_W]) begin
                sat_d   = 1'b1;
                clamp_d = {DATA_W{1'b1}};
            end
        end
    end

    // Sequencer, pipeline and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sela_q     <= '0;
            selb_q     <= '0;
            fns_q      <= '0;
            sgn_q      <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            opv_q      <= 1'b0;
            opl_q      <= 1'b0;
            for (int i = 0; i < PIPE; i++) prod_q[i] <= '0;
            pv_q       <= '0;
            pl_q       <= '0;
            acc_q      <= '0;
            flow_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Operand stage: one sample per RUN cycle while samples remain
            opa_q <= opa_d;
            opb_q <= opb_d;
            opv_q <= (state_q == S_RUN) && (cnt_q != '0);
            opl_q <= (state_q == S_RUN) && (cnt_q == LEN_W'(1));

            // Product stages
            prod_q[0] <= prod_d;
            pv_q[0]   <= opv_q;
            pl_q[0]   <= opl_q;
            for (int i = 1; i < PIPE; i++) begin
                prod_q[i] <= prod_q[i-1];
                pv_q[i]   <= pv_q[i-1];
                pl_q[i]   <= pl_q[i-1];
            end

            // Consume a valid product leaving the pipe
            if (pv_q[PIPE-1]) begin
                if (fns_q == FN_MAC) begin
                    acc_q   <= acc_d;
                    first_q <= 1'b0;
                    if (pl_q[PIPE-1]) begin
                        flow_out_q <= clamp_d;
                        sat_q      <= sat_d;
                    end
                end else begin
                    flow_out_q <= res_d;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        sela_q  <= cfg_sela;
                        selb_q  <= cfg_selb;
                        fns_q   <= cfg_fns;
                        sgn_q   <= cfg_signed;
                        shift_q <= cfg_shift;
                        cnt_q   <= cfg_len;
                        first_q <= 1'b1;
                        sat_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        // Empty run: nothing enters the pipe
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        if (fns_q == FN_MAC) begin
                            flow_out_q <= '0;
                            sat_q      <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pv_q[PIPE-1] && pl_q[PIPE-1]) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sat      = sat_q;
    assign flow_out = flow_out_q;

endmodule
`default_nettype wire
